// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl: interlocked one-hot TV/PC/ALEX enable with debounce, min on-time and break-before-make gap.
// Optional SEMAFORO_STATUS_EN adds estado/trocas status outputs.
module semaforo_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 4,
  parameter int MIN_ON_CYC  = 8,
  parameter int GAP_CYC     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  output logic       TV,
  output logic       PC,
  output logic       ALEX
`ifdef SEMAFORO_STATUS_EN
  ,
  output logic [1:0] estado,
  output logic [7:0] trocas
`endif
);
  localparam int SW = $clog2(STABLE_CYC) + 1;
  localparam int OW = $clog2(MIN_ON_CYC) + 1;
  localparam int GW = $clog2(GAP_CYC) + 1;
  typedef enum logic [1:0] {IDLE = 2'b00, ON = 2'b01, GAP = 2'b10} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic [1:0] cur, last, acc, sel, sel_n;
  logic [SW-1:0] st_cnt, st_nxt;
  logic [OW-1:0] on_cnt;
  logic [GW-1:0] gap_cnt;
  assign cur = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
  assign st_nxt = (cur != last) ? SW'(1) : (st_cnt >= SW'(STABLE_CYC) ? st_cnt : st_cnt + 1'b1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
      last   <= '0;
      st_cnt <= '0;
      acc    <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], A};
      b_sync <= {b_sync[SYNC_STAGES-2:0], B};
      last   <= cur;
      st_cnt <= st_nxt;
      if (st_nxt == SW'(STABLE_CYC)) acc <= cur;
    end
  end
  always_comb begin
    state_n = state;
    sel_n   = sel;
    case (state)
      IDLE: if (acc != 2'b00) begin
        state_n = ON;
        sel_n   = acc;
      end
      ON: if (acc != sel && on_cnt >= OW'(MIN_ON_CYC)) state_n = GAP;
      GAP: if (gap_cnt == GW'(GAP_CYC - 1)) begin
        state_n = (acc == 2'b00) ? IDLE : ON;
        sel_n   = acc;
      end
      default: state_n = IDLE;
    endcase
  end
  // Enables are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      on_cnt  <= '0;
      gap_cnt <= '0;
      TV      <= 1'b0;
      PC      <= 1'b0;
      ALEX    <= 1'b0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      on_cnt  <= (state != ON) ? '0 : (on_cnt >= OW'(MIN_ON_CYC) ? on_cnt : on_cnt + 1'b1);
      gap_cnt <= (state == GAP && state_n == GAP) ? gap_cnt + 1'b1 : '0;
      TV      <= state_n == ON && sel_n == 2'b01;
      PC      <= state_n == ON && sel_n == 2'b10;
      ALEX    <= state_n == ON && sel_n == 2'b11;
    end
  end
`ifdef SEMAFORO_STATUS_EN
  assign estado = state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trocas <= '0;
    else trocas <= trocas + 8'(state_n == ON && state != ON);
  end
`endif
endmodule

// File: tb/tb_semaforo_ctrl.sv
// tb_semaforo_ctrl: scoreboard bench; stimulus queues expected output changes, a negedge monitor checks them.
module tb_semaforo_ctrl;
  logic clk = 0, rst_n = 0, A = 1, B = 1;
  logic TV, PC, ALEX;
`ifdef SEMAFORO_STATUS_EN
  logic [1:0] estado;
  logic [7:0] trocas;
`endif
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int cyc; logic [2:0] val;} ev_t;
  ev_t q[$];
  ev_t e;
  logic [2:0] prev = 3'b000, mon_v;
  logic [1:0] codes [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
  logic [1:0] p;

  semaforo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .TV(TV), .PC(PC), .ALEX(ALEX)
`ifdef SEMAFORO_STATUS_EN
    , .estado(estado), .trocas(trocas)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] hot(input logic [1:0] c);
    return c == 2'd1 ? 3'b100 : c == 2'd2 ? 3'b010 : c == 2'd3 ? 3'b001 : 3'b000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [1:0] c);
    {A, B} = c;
  endtask

  task automatic push(input int c, input logic [2:0] v);
    q.push_back('{cyc: c, val: v});
  endtask

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    mon_v = {TV, PC, ALEX};
    if ($countones(mon_v) > 1) begin
      fails++;
      $display("FAIL onehot: outputs %b at cycle %0d", mon_v, cyc);
    end
    while (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL missed_change: expected %b at cycle %0d, not observed (now %0d, outputs %b)", e.val, e.cyc, cyc, mon_v);
    end
    if (mon_v !== prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %b at cycle %0d, expected no change from %b", mon_v, cyc, prev);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.val !== mon_v) begin
          fails++;
          $display("FAIL change: got %b at cycle %0d, expected %b at cycle %0d", mon_v, cyc, e.val, e.cyc);
        end
      end
      prev = mon_v;
    end
  end

  initial begin
    step(3);
    chk("reset_outputs", int'({TV, PC, ALEX}), 0);
    go(2'b00);
    rst_n = 1;
    step(20);
    go(2'b01); push(cyc + 7, 3'b100); step(20);
    go(2'b10); push(cyc + 7, 3'b000); push(cyc + 9, 3'b010); step(20);
    go(2'b11); push(cyc + 7, 3'b000); push(cyc + 9, 3'b001); step(11);
    go(2'b00); push(cyc + 7, 3'b000); step(20);
    go(2'b01); push(cyc + 7, 3'b100); step(7);
    go(2'b00); push(cyc + 9, 3'b000); step(20);
    go(2'b01); step(3);
    go(2'b00); step(20);
    go(2'b01); push(cyc + 7, 3'b100); step(4);
    go(2'b00); push(cyc + 12, 3'b000); step(25);
    p = 2'd0;
    foreach (codes[i]) begin
      go(codes[i]);
      if (codes[i] != p) begin
        if (p == 2'd0) push(cyc + 7, hot(codes[i]));
        else begin
          push(cyc + 7, 3'b000);
          push(cyc + 9, hot(codes[i]));
        end
      end
      p = codes[i];
      step(20);
    end
    push(cyc, 3'b000);
    rst_n = 0;
    #1;
    chk("async_reset_drop", int'({TV, PC, ALEX}), 0);
    step(2);
    rst_n = 1;
    push(cyc + 7, 3'b001);
    step(15);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
